reset_seq: RTL and testbench
============================

RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 Parameter GAP_CYCLES, default 16: clock cycles between successive subsystem reset releases (legal range 1..65535).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum wait for pll_locked or mem_init_done before FAULT (legal range 2..2^24-1).
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, driven by the upstream reset block; it is also the sequence start trigger.
REQ-005 pll_locked  input  1  PLL lock status, already synchronous to clk.
REQ-006 mem_init_done  input  1  memory controller init complete, level, synchronous to clk.
REQ-007 rst_mem_n  output  1  active-low reset to the memory controller.
REQ-008 rst_video_n  output  1  active-low reset to the video subsystem.
REQ-009 rst_cpu_n  output  1  active-low reset to the CPU/bus subsystem.
REQ-010 sys_ready  output  1  high while all subsystems are released.
REQ-011 fault  output  1  high while a sequencing timeout is latched.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 FSM states: HOLD, WAIT_PLL, WAIT_MEM, GAP_VIDEO, GAP_CPU, RUN, FAULT; one shared counter sized with $clog2 of max(GAP_CYCLES, TIMEOUT_CYCLES)+1.
REQ-014 HOLD: all rst_*_n=0, sys_ready=0, fault=0; go to WAIT_PLL on the first edge that samples reset=1.
REQ-015 WAIT_PLL: on an edge sampling pll_locked=1, go to WAIT_MEM, set rst_mem_n=1, clear the counter.
REQ-016 WAIT_MEM: on an edge sampling mem_init_done=1, go to GAP_VIDEO and clear the counter.
REQ-017 GAP_VIDEO: increment the counter each edge; on the edge sampling counter==GAP_CYCLES-1, go to GAP_CPU, set rst_video_n=1, clear the counter.
REQ-018 GAP_CPU: same counting; on counter==GAP_CYCLES-1, go to RUN and set rst_cpu_n=1 and sys_ready=1 on the same edge.
REQ-019 Release order SHALL be mem, then video, then cpu; no subsystem is released before its predecessor.
REQ-020 Latency: reset sampled high at edge k, with pll_locked and mem_init_done already high: rst_mem_n at k+1, rst_video_n at k+2+GAP_CYCLES, rst_cpu_n and sys_ready at k+2+2*GAP_CYCLES.
REQ-021 pll_locked sampled 0 in WAIT_MEM, GAP_VIDEO, GAP_CPU or RUN: go to HOLD; all rst_*_n=0 and sys_ready=0 on the next edge; then restart at WAIT_PLL.
REQ-022 mem_init_done falling after WAIT_MEM SHALL be ignored.
REQ-023 FAULT: all rst_*_n=0, sys_ready=0, fault=1; exit only through reset=0.
REQ-024 Simultaneous reset=0 and any other event: reset wins.

Reset
REQ-025 An edge sampling reset=0 in any state SHALL load HOLD, counter=0, all rst_*_n=0, sys_ready=0, fault=0.
REQ-026 Reset asserted mid-sequence SHALL re-assert every already-released subsystem reset on that edge.

Configuration
REQ-027 Macro RESET_SEQ_TIMEOUT_EN defined: in WAIT_PLL and WAIT_MEM the counter increments each edge; the edge sampling counter==TIMEOUT_CYCLES-1 with the awaited input still 0 goes to FAULT.
REQ-028 RESET_SEQ_TIMEOUT_EN undefined: WAIT_PLL and WAIT_MEM wait indefinitely, FAULT is unreachable, fault is tied 0, and the counter is sized for GAP_CYCLES only.

Structure
REQ-029 Package reset_seq_pkg SHALL hold the state enum typedef and the default GAP_CYCLES/TIMEOUT_CYCLES constants.
REQ-030 The counter SHALL be one sub-module, reset_seq_timer (clear, enable, terminal-count compare), instantiated once.

Verification
REQ-031 GAP_CYCLES=4, pll_locked=1 and mem_init_done=1 tied high, reset released at edge k -> rst_mem_n rises at k+1, rst_video_n at k+6, rst_cpu_n and sys_ready at k+10.
REQ-032 pll_locked=0 for 50 cycles after reset release, then 1 -> all resets stay 0 until pll_locked is sampled 1; rst_mem_n rises 1 edge later.
REQ-033 In RUN, pull pll_locked to 0 for 1 cycle -> all three resets and sys_ready go 0 on the next edge; full sequence repeats with the same spacing.
REQ-034 Macro defined, TIMEOUT_CYCLES=100, mem_init_done held 0 -> fault=1 and rst_mem_n=0 at 100 edges after entering WAIT_MEM; reset=0 clears fault on the next edge.
REQ-035 reset=0 during GAP_CPU (rst_mem_n and rst_video_n already 1) -> both go 0 on the sampling edge; no release happens while reset=0.
REQ-036 Macro undefined, mem_init_done held 0 for 10^6 cycles -> no FAULT, fault stays 0, sequence completes once mem_init_done goes 1.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg -- shared types and defaults for the reset sequencer.
//   state_e            : sequencer FSM state encoding
//   DEF_GAP_CYCLES     : default spacing between subsystem releases
//   DEF_TIMEOUT_CYCLES : default wait limit for pll_locked / mem_init_done
//   max_u              : elaboration-time helper for counter sizing
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_PLL,
    WAIT_MEM,
    GAP_VIDEO,
    GAP_CPU,
    RUN,
    FAULT
  } state_e;

  localparam int unsigned DEF_GAP_CYCLES     = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// reset_seq_timer -- shared up-counter with clear, enable and terminal compare.
//   clk     : system clock
//   rst_n   : synchronous active-low reset (clears the count)
//   clr_i   : clear count to 0 (wins over en_i)
//   en_i    : increment count
//   term_i  : terminal value to compare against
//   tc_o    : high while count == term_i (from the registered count)
module reset_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) cnt_q <= '0;
    else if (en_i)       cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/reset_seq.sv
// reset_seq -- ordered subsystem reset release: mem, then video, then cpu.
//   clk           : system clock
//   reset         : synchronous active-low reset; its release starts the sequence
//   pll_locked    : PLL lock (clk-synchronous); loss of lock restarts the sequence
//   mem_init_done : memory init complete (level)
//   rst_mem_n     : memory controller reset (active low)
//   rst_video_n   : video subsystem reset (active low)
//   rst_cpu_n     : CPU/bus subsystem reset (active low)
//   sys_ready     : all subsystems released
//   fault         : sequencing timeout latched
// Optional: define RESET_SEQ_TIMEOUT_EN to bound the PLL / memory-init waits
// by TIMEOUT_CYCLES and enter FAULT on expiry. Without it the waits are
// unbounded and fault is constant 0.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_locked,
  input  logic mem_init_done,
  output logic rst_mem_n,
  output logic rst_video_n,
  output logic rst_cpu_n,
  output logic sys_ready,
  output logic fault
);

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(max_u(GAP_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] TMO_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
`else
  localparam int CNT_W = $clog2(GAP_CYCLES + 1);
`endif
  localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'(GAP_CYCLES - 1);

  state_e           state_q;
  logic             mem_q, video_q, cpu_q, ready_q;
  logic             tmr_clr, tmr_en, tmr_tc;
  logic [CNT_W-1:0] tmr_term;

  // Timer control. The count is held at 0 except while a gap (or, with the
  // timeout enabled, a wait) is being timed, and is cleared on the edge that
  // leaves a timed state so the next state starts from 0.
  always_comb begin
    tmr_clr  = 1'b1;
    tmr_en   = 1'b0;
    tmr_term = GAP_TERM;
    case (state_q)
`ifdef RESET_SEQ_TIMEOUT_EN
      WAIT_PLL: if (!pll_locked) begin
        tmr_clr = 1'b0; tmr_en = 1'b1; tmr_term = TMO_TERM;
      end
      WAIT_MEM: if (pll_locked && !mem_init_done) begin
        tmr_clr = 1'b0; tmr_en = 1'b1; tmr_term = TMO_TERM;
      end
`endif
      GAP_VIDEO, GAP_CPU: if (pll_locked && !tmr_tc) begin
        tmr_clr = 1'b0; tmr_en = 1'b1;
      end
      default: ;
    endcase
  end

  reset_seq_timer #(.W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .term_i (tmr_term),
    .tc_o   (tmr_tc)
  );

`ifdef RESET_SEQ_TIMEOUT_EN
  logic fault_q;
`endif

  // Sequencer with registered outputs. Loss of PLL lock after WAIT_PLL drops
  // every reset back to asserted on the sampling edge, then replays from HOLD.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= HOLD;
      mem_q   <= 1'b0;
      video_q <= 1'b0;
      cpu_q   <= 1'b0;
      ready_q <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        HOLD: state_q <= WAIT_PLL;
        WAIT_PLL: begin
          if (pll_locked) begin
            state_q <= WAIT_MEM;
            mem_q   <= 1'b1;
          end
`ifdef RESET_SEQ_TIMEOUT_EN
          else if (tmr_tc) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end
`endif
        end
        WAIT_MEM, GAP_VIDEO, GAP_CPU, RUN: begin
          if (!pll_locked) begin
            state_q <= HOLD;
            mem_q   <= 1'b0;
            video_q <= 1'b0;
            cpu_q   <= 1'b0;
            ready_q <= 1'b0;
          end else if (state_q == WAIT_MEM) begin
            // mem_init_done is only looked at here; later drops are ignored.
            if (mem_init_done) state_q <= GAP_VIDEO;
`ifdef RESET_SEQ_TIMEOUT_EN
            else if (tmr_tc) begin
              state_q <= FAULT;
              mem_q   <= 1'b0;
              fault_q <= 1'b1;
            end
`endif
          end else if (state_q == GAP_VIDEO && tmr_tc) begin
            state_q <= GAP_CPU;
            video_q <= 1'b1;
          end else if (state_q == GAP_CPU && tmr_tc) begin
            state_q <= RUN;
            cpu_q   <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        FAULT: state_q <= FAULT;
        default: state_q <= HOLD;
      endcase
    end
  end

  assign rst_mem_n   = mem_q;
  assign rst_video_n = video_q;
  assign rst_cpu_n   = cpu_q;
  assign sys_ready   = ready_q;
`ifdef RESET_SEQ_TIMEOUT_EN
  assign fault       = fault_q;
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq -- directed bench for reset_seq with GAP_CYCLES=4,
// TIMEOUT_CYCLES=100. Observed outputs are packed as
// {rst_mem_n, rst_video_n, rst_cpu_n, sys_ready, fault}.
module tb_reset_seq;

  logic clk = 1'b0;
  logic reset, pll_locked, mem_init_done;
  logic rst_mem_n, rst_video_n, rst_cpu_n, sys_ready, fault;

  int vectors   = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reset_seq #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .clk           (clk),
    .reset         (reset),
    .pll_locked    (pll_locked),
    .mem_init_done (mem_init_done),
    .rst_mem_n     (rst_mem_n),
    .rst_video_n   (rst_video_n),
    .rst_cpu_n     (rst_cpu_n),
    .sys_ready     (sys_ready),
    .fault         (fault)
  );

  wire [4:0] obs = {rst_mem_n, rst_video_n, rst_cpu_n, sys_ready, fault};

  // Advance one rising edge; outputs are read 1 time unit after it and
  // inputs changed here are sampled on the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs n edges after the HOLD->WAIT_PLL edge with pll and mem
  // high and GAP=4: mem at 1, video at 2+4=6, cpu/ready at 2+8=10.
  function automatic logic [4:0] seq_exp(input int n);
    return {n >= 1, n >= 6, n >= 10, n >= 10, 1'b0};
  endfunction

  task automatic test_reset();
    reset = 1'b0; pll_locked = 1'b1; mem_init_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs !== 5'b00000) begin
        miscompares++;
        $display("FAIL reset_state cyc%0d got=%b want=%b", i, obs, 5'b00000);
      end
    end
  endtask

  task automatic test_latency();
    reset = 1'b1;
    for (int n = 0; n <= 12; n++) begin
      tick();
      vectors++;
      if (obs !== seq_exp(n)) begin
        miscompares++;
        $display("FAIL latency k+%0d got=%b want=%b", n, obs, seq_exp(n));
      end
    end
  endtask

  task automatic test_pll_wait();
    reset = 1'b0; tick();
    pll_locked = 1'b0; reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      vectors++;
      if (obs !== 5'b00000) begin
        miscompares++;
        $display("FAIL pll_wait cyc%0d got=%b want=%b", i, obs, 5'b00000);
      end
    end
    pll_locked = 1'b1;
    tick();
    vectors++;
    if (obs !== 5'b10000) begin
      miscompares++;
      $display("FAIL pll_lock_mem got=%b want=%b", obs, 5'b10000);
    end
    for (int i = 0; i < 12; i++) tick();
    vectors++;
    if (obs !== 5'b11110) begin
      miscompares++;
      $display("FAIL pll_wait_run got=%b want=%b", obs, 5'b11110);
    end
  endtask

  task automatic test_pll_drop();
    pll_locked = 1'b0;
    tick();
    vectors++;
    if (obs !== 5'b00000) begin
      miscompares++;
      $display("FAIL pll_drop got=%b want=%b", obs, 5'b00000);
    end
    pll_locked = 1'b1;
    for (int n = 0; n <= 12; n++) begin
      tick();
      vectors++;
      if (obs !== seq_exp(n)) begin
        miscompares++;
        $display("FAIL relock k+%0d got=%b want=%b", n, obs, seq_exp(n));
      end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0; tick();
    reset = 1'b1;
    for (int n = 0; n <= 7; n++) tick();
    vectors++;
    if (obs !== 5'b11000) begin
      miscompares++;
      $display("FAIL mid_gap_cpu got=%b want=%b", obs, 5'b11000);
    end
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      vectors++;
      if (obs !== 5'b00000) begin
        miscompares++;
        $display("FAIL mid_reset cyc%0d got=%b want=%b", i, obs, 5'b00000);
      end
    end
  endtask

`ifdef RESET_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    reset = 1'b0; tick();
    mem_init_done = 1'b0; reset = 1'b1;
    tick();                  // edge k: WAIT_PLL
    tick();                  // edge k+1: WAIT_MEM entered
    vectors++;
    if (obs !== 5'b10000) begin
      miscompares++;
      $display("FAIL tmo_enter got=%b want=%b", obs, 5'b10000);
    end
    for (int i = 0; i < 99; i++) tick();
    vectors++;
    if (obs !== 5'b10000) begin
      miscompares++;
      $display("FAIL tmo_edge99 got=%b want=%b", obs, 5'b10000);
    end
    tick();                  // 100th edge after entering WAIT_MEM
    vectors++;
    if (obs !== 5'b00001) begin
      miscompares++;
      $display("FAIL tmo_fault got=%b want=%b", obs, 5'b00001);
    end
    mem_init_done = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (obs !== 5'b00001) begin
      miscompares++;
      $display("FAIL tmo_sticky got=%b want=%b", obs, 5'b00001);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (obs !== 5'b00000) begin
      miscompares++;
      $display("FAIL tmo_clear got=%b want=%b", obs, 5'b00000);
    end
  endtask
`else
  task automatic test_no_timeout();
    reset = 1'b0; tick();
    mem_init_done = 1'b0; reset = 1'b1;
    tick(); tick();
    for (int i = 0; i < 2000; i++) tick();
    vectors++;
    if (obs !== 5'b10000) begin
      miscompares++;
      $display("FAIL mem_wait got=%b want=%b", obs, 5'b10000);
    end
    mem_init_done = 1'b1;
    tick();                  // edge m: GAP_VIDEO
    for (int n = 1; n <= 8; n++) begin
      tick();
      vectors++;
      if (obs !== {1'b1, n >= 4, n >= 8, n >= 8, 1'b0}) begin
        miscompares++;
        $display("FAIL mem_late m+%0d got=%b want=%b", n, obs,
                 {1'b1, n >= 4, n >= 8, n >= 8, 1'b0});
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b0; pll_locked = 1'b1; mem_init_done = 1'b1;
    test_reset();
    test_latency();
    test_pll_wait();
    test_pll_drop();
    test_reset_mid();
`ifdef RESET_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
